branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the RV32I pipeline. It pairs a direct-mapped branch target buffer with per-entry saturating direction counters.
- The fetch stage queries it every cycle for a predicted next PC.
- The execute stage reports resolved branches and jumps, and receives a mispredict/redirect indication in return.
- It replaces static "always not taken" fetch with learned prediction, and adds performance counters for branch statistics.

---
 rtl/branch_predictor.sv | 80 ++++++++
 tb/tb_branch_predictor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters, mispredict detection and perf counters
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_target,
  input  logic            e_valid,
  input  logic [XLEN-1:0] e_pc,
  input  logic            e_is_br,
  input  logic            e_is_jump,
  input  logic            e_taken,
  input  logic [XLEN-1:0] e_target,
  input  logic            e_pred_taken,
  input  logic [XLEN-1:0] e_pred_target,
  output logic            e_mispredict,
  output logic [XLEN-1:0] e_redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispred
);
  localparam int N  = 1 << IDX_BITS;
  localparam int TW = XLEN - IDX_BITS - 2;
  localparam logic [CNT_W-1:0] WNT = CNT_W'((1 << (CNT_W-1)) - 1);
  localparam logic [CNT_W-1:0] WT  = CNT_W'(1 << (CNT_W-1));
  localparam logic [CNT_W-1:0] MAX = '1;
  logic                v_q   [N];
  logic [TW-1:0]       tag_q [N];
  logic [XLEN-1:0]     tgt_q [N];
  logic [CNT_W-1:0]    ctr_q [N];
  logic [IDX_BITS-1:0] f_idx, e_idx;
  logic [TW-1:0]       f_tag, e_tag;
  logic                f_hit, e_hit, e_bj;
  always_comb begin
    f_idx         = f_pc[IDX_BITS+1:2];
    f_tag         = f_pc[XLEN-1:IDX_BITS+2];
    e_idx         = e_pc[IDX_BITS+1:2];
    e_tag         = e_pc[XLEN-1:IDX_BITS+2];
    f_hit         = v_q[f_idx] && tag_q[f_idx] == f_tag;
    e_hit         = v_q[e_idx] && tag_q[e_idx] == e_tag;
    e_bj          = e_is_br | e_is_jump;
    f_pred_taken  = f_hit & ctr_q[f_idx][CNT_W-1];
    f_pred_target = f_pred_taken ? tgt_q[f_idx] : f_pc + XLEN'(4);
    e_mispredict  = e_valid & (e_bj ? (e_pred_taken != e_taken) | (e_taken & (e_pred_target != e_target))
                                    : e_pred_taken);
    e_redirect_pc = e_bj & e_taken ? e_target : e_pc + XLEN'(4);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= WNT;
      end
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      if (e_valid) begin
        if (e_is_jump || (e_is_br && e_taken && !e_hit)) begin
          v_q[e_idx]   <= 1'b1;
          tag_q[e_idx] <= e_tag;
          tgt_q[e_idx] <= e_target;
          ctr_q[e_idx] <= e_is_jump ? MAX : WT;
        end else if (e_is_br && e_hit) begin
          if (e_taken) tgt_q[e_idx] <= e_target;
          ctr_q[e_idx] <= e_taken ? (ctr_q[e_idx] == MAX ? MAX : ctr_q[e_idx] + 1'b1)
                                  : (ctr_q[e_idx] == '0 ? '0 : ctr_q[e_idx] - 1'b1);
        end else if (!e_bj && e_pred_taken && e_hit) begin
          v_q[e_idx] <= 1'b0;
        end
      end
      if (e_valid && e_bj) perf_branches <= perf_branches + 32'd1;
      if (e_mispredict) perf_mispred <= perf_mispred + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plan plus randomized traffic against a table-level reference model
module tb_branch_predictor;
  logic        clk = 0, rst_n = 0;
  logic [31:0] f_pc = 0, e_pc = 0, e_target = 0, e_pred_target = 0;
  logic        e_valid = 0, e_is_br = 0, e_is_jump = 0, e_taken = 0, e_pred_taken = 0;
  logic        f_pred_taken, e_mispredict;
  logic [31:0] f_pred_target, e_redirect_pc, perf_branches, perf_mispred;
  int          n_chk = 0, n_fail = 0;
  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic [31:0] m_pb, m_pm;
  always #5 clk = ~clk;
  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .e_valid(e_valid), .e_pc(e_pc), .e_is_br(e_is_br), .e_is_jump(e_is_jump), .e_taken(e_taken),
    .e_target(e_target), .e_pred_taken(e_pred_taken), .e_pred_target(e_pred_target),
    .e_mispredict(e_mispredict), .e_redirect_pc(e_redirect_pc),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int ix(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction
  function automatic bit hit(input logic [31:0] pc);
    return m_v[ix(pc)] && m_tag[ix(pc)] == pc / 64;
  endfunction
  function automatic bit pred(input logic [31:0] pc);
    return hit(pc) && m_ctr[ix(pc)] >= 2;
  endfunction
  function automatic logic [31:0] ptgt(input logic [31:0] pc);
    return pred(pc) ? m_tgt[ix(pc)] : pc + 4;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_pb = 0; m_pm = 0;
  endtask
  task automatic cyc(input bit v, input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                     input logic [31:0] tgt, input bit pt, input logic [31:0] ptg, input logic [31:0] fpc);
    bit bj, mis;
    int k;
    e_valid = v; e_pc = pc; e_is_br = br; e_is_jump = jmp; e_taken = tk;
    e_target = tgt; e_pred_taken = pt; e_pred_target = ptg; f_pc = fpc;
    bj  = br || jmp;
    mis = v && (bj ? (pt != tk) || (tk && ptg != tgt) : pt);
    #1;
    check("f_pred_taken", f_pred_taken, pred(fpc));
    check("f_pred_target", f_pred_target, ptgt(fpc));
    check("e_mispredict", e_mispredict, mis);
    check("e_redirect_pc", e_redirect_pc, bj && tk ? tgt : pc + 4);
    @(posedge clk);
    k = ix(pc);
    if (v) begin
      if (jmp || (br && tk && !hit(pc))) begin
        m_v[k] = 1; m_tag[k] = pc / 64; m_tgt[k] = tgt; m_ctr[k] = jmp ? 3 : 2;
      end else if (br && hit(pc)) begin
        if (tk) m_tgt[k] = tgt;
        m_ctr[k] = tk ? (m_ctr[k] < 3 ? m_ctr[k] + 1 : 3) : (m_ctr[k] > 0 ? m_ctr[k] - 1 : 0);
      end else if (!bj && pt && hit(pc)) m_v[k] = 0;
      if (bj) m_pb++;
    end
    if (mis) m_pm++;
    #1;
    check("perf_branches", perf_branches, m_pb);
    check("perf_mispred", perf_mispred, m_pm);
  endtask
  task automatic idle(input logic [31:0] fpc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, fpc);
  endtask
  initial begin
    logic [31:0] pc, tgt, ptg;
    bit br, jmp, tk, pt;
    int ty;
    model_reset();
    f_pc = 32'h100;
    #12;
    check("rst_pred_taken", f_pred_taken, 0);
    check("rst_pred_target", f_pred_target, 32'h104);
    check("rst_perf_b", perf_branches, 0);
    check("rst_perf_m", perf_mispred, 0);
    rst_n = 1;
    @(posedge clk); #1;
    idle(32'h100);
    e_valid = 1; e_pc = 32'h40; e_is_br = 1; e_taken = 1; e_target = 32'h20; #1;
    check("beq_mispredict", e_mispredict, 1);
    check("beq_redirect", e_redirect_pc, 32'h20);
    cyc(1, 32'h40, 1, 0, 1, 32'h20, 0, 0, 32'h40);
    idle(32'h40);
    check("beq_learned", f_pred_taken, 1);
    check("beq_target", f_pred_target, 32'h20);
    check("beq_perf_m", perf_mispred, 1);
    repeat (3) cyc(1, 32'h40, 1, 0, 1, 32'h20, 1, 32'h20, 32'h40);
    cyc(1, 32'h40, 1, 0, 0, 32'h20, 1, 32'h20, 32'h40);
    idle(32'h40);
    check("ctr2_taken", f_pred_taken, 1);
    cyc(1, 32'h40, 1, 0, 0, 32'h20, 1, 32'h20, 32'h40);
    idle(32'h40);
    check("ctr1_not_taken", f_pred_taken, 0);
    cyc(1, 32'h80, 0, 1, 1, 32'h400, 0, 0, 32'h80);
    idle(32'h80);
    check("jal_target", f_pred_target, 32'h400);
    cyc(1, 32'hC0, 0, 0, 0, 0, 1, 32'h999, 32'h80);
    cyc(1, 32'h80, 0, 0, 0, 0, 1, 32'h400, 32'h80);
    idle(32'h80);
    check("alias_invalidated", f_pred_taken, 0);
    cyc(1, 32'h48, 1, 0, 1, 32'h50, 0, 0, 32'h48);
    e_valid = 1; e_pc = 32'h48; e_is_br = 1; e_taken = 1; e_target = 32'h60;
    e_pred_taken = 1; e_pred_target = 32'h50; #1;
    check("tgt_mispredict", e_mispredict, 1);
    check("tgt_redirect", e_redirect_pc, 32'h60);
    cyc(1, 32'h48, 1, 0, 1, 32'h60, 1, 32'h50, 32'h48);
    idle(32'h48);
    check("tgt_updated", f_pred_target, 32'h60);
    for (int i = 0; i < 400; i++) begin
      pc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 5) << 2);
      ty  = $urandom_range(0, 3);
      jmp = ty == 1;
      br  = ty >= 2;
      tk  = jmp || (br && $urandom_range(0, 1) == 1);
      tgt = $urandom & 32'hFFC;
      pt  = $urandom_range(0, 3) == 0 ? $urandom_range(0, 1) == 1 : pred(pc);
      ptg = $urandom_range(0, 3) == 0 ? tgt : ptgt(pc);
      cyc($urandom_range(0, 9) != 0, pc, br, jmp, tk, tgt, pt, ptg,
          ($urandom_range(0, 2) << 6) | ($urandom_range(0, 5) << 2));
    end
    force dut.perf_branches = 32'hFFFF_FFFF;
    #1 release dut.perf_branches;
    m_pb = 32'hFFFF_FFFF;
    cyc(1, 32'h40, 1, 0, 1, 32'h20, pred(32'h40), ptgt(32'h40), 32'h40);
    check("perf_wrap", perf_branches, 0);
    cyc(1, 32'h80, 0, 1, 1, 32'h400, 0, 0, 32'h80);
    idle(32'h80);
    rst_n = 0; #1;
    check("mid_rst_taken", f_pred_taken, 0);
    check("mid_rst_target", f_pred_target, 32'h84);
    check("mid_rst_perf_b", perf_branches, 0);
    check("mid_rst_perf_m", perf_mispred, 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    idle(32'h80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
